// File: rtl/vector_sequencer.sv
// XY vector display command sequencer: JUMP/DRAW commands in, per-axis DAC samples out.
// Optional endpoint dwell is enabled with VECTOR_SEQ_DWELL_EN (adds DWELL_CYCLES, D_DWELL).
module vector_sequencer #(
    parameter int WIDTH         = 12,
    parameter int SETTLE_CYCLES = 64,
    parameter int SETTLE_W      = 8
`ifdef VECTOR_SEQ_DWELL_EN
    ,
    parameter int DWELL_CYCLES  = 8
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_op,
    input  logic [WIDTH-1:0] cmd_x,
    input  logic [WIDTH-1:0] cmd_y,
    output logic             dac_valid,
    input  logic             dac_ready,
    output logic [WIDTH-1:0] dac_value,
    output logic             dac_axis,
    output logic             beam_on,
    output logic             busy
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_JX     = 4'd1;
    localparam logic [3:0] S_JY     = 4'd2;
    localparam logic [3:0] S_SETTLE = 4'd3;
    localparam logic [3:0] S_DINIT  = 4'd4;
    localparam logic [3:0] S_DSTEP  = 4'd5;
    localparam logic [3:0] S_DX     = 4'd6;
    localparam logic [3:0] S_DY     = 4'd7;
    localparam logic [3:0] S_DWELL  = 4'd8;

    localparam int EW = WIDTH + 2;

    logic [3:0]             state_q, state_d;
    logic [WIDTH-1:0]       cur_x_q, cur_x_d;
    logic [WIDTH-1:0]       cur_y_q, cur_y_d;
    logic [WIDTH-1:0]       tx_q, tx_d;
    logic [WIDTH-1:0]       ty_q, ty_d;
    logic [WIDTH-1:0]       dx_q, dx_d;
    logic [WIDTH-1:0]       dy_q, dy_d;
    logic                   sx_q, sx_d;
    logic                   sy_q, sy_d;
    logic signed [EW-1:0]   err_q, err_d;
    logic [SETTLE_W-1:0]    cnt_q, cnt_d;
    logic                   vld_q, vld_d;
    logic [WIDTH-1:0]       val_q, val_d;
    logic                   axis_q, axis_d;
    logic                   beam_q, beam_d;
    logic                   ychg_q, ychg_d;

    logic                   xfer;
    logic                   at_tgt;
    logic [WIDTH-1:0]       init_dx, init_dy;
    logic signed [EW:0]     e2;
    logic                   stepx, stepy;
    logic signed [EW-1:0]   sub_v, add_v, err_step;
    logic [WIDTH-1:0]       nx, ny;
    logic [3:0]             done_state;
    logic [SETTLE_W-1:0]    done_cnt;
    logic [3:0]             fin_state;
    logic [SETTLE_W-1:0]    fin_cnt;

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign dac_valid = vld_q;
    assign dac_value = val_q;
    assign dac_axis  = axis_q;
    assign beam_on   = beam_q;

    assign xfer   = vld_q && dac_ready;
    assign at_tgt = (cur_x_q == tx_q) && (cur_y_q == ty_q);

    // Bresenham stepper datapath; err never overflows EW bits for any endpoints
    always_comb begin
        init_dx = (tx_q >= cur_x_q) ? tx_q - cur_x_q : cur_x_q - tx_q;
        init_dy = (ty_q >= cur_y_q) ? ty_q - cur_y_q : cur_y_q - ty_q;
        e2      = $signed({err_q, 1'b0});
        stepx   = e2 > -$signed({3'b000, dy_q});
        stepy   = e2 < $signed({3'b000, dx_q});
        sub_v   = '0;
        add_v   = '0;
        if (stepx) sub_v = $signed({2'b00, dy_q});
        if (stepy) add_v = $signed({2'b00, dx_q});
        err_step = err_q - sub_v + add_v;
        nx = cur_x_q;
        ny = cur_y_q;
        if (stepx) nx = sx_q ? cur_x_q - 1'b1 : cur_x_q + 1'b1;
        if (stepy) ny = sy_q ? cur_y_q - 1'b1 : cur_y_q + 1'b1;
    end

    // Where a draw goes once its final point has been transferred
`ifdef VECTOR_SEQ_DWELL_EN
    assign done_state = (DWELL_CYCLES == 0) ? S_IDLE : S_DWELL;
    assign done_cnt   = SETTLE_W'(DWELL_CYCLES);
`else
    assign done_state = S_IDLE;
    assign done_cnt   = '0;
`endif
    assign fin_state = at_tgt ? done_state : S_DSTEP;
    assign fin_cnt   = at_tgt ? done_cnt : cnt_q;

    // Next-state logic for the sequencer FSM and its datapath registers
    always_comb begin
        state_d = state_q;
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        tx_d    = tx_q;
        ty_d    = ty_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        vld_d   = vld_q;
        val_d   = val_q;
        axis_d  = axis_q;
        beam_d  = beam_q;
        ychg_d  = ychg_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    tx_d = cmd_x;
                    ty_d = cmd_y;
                    if (cmd_op) begin
                        state_d = S_DINIT;
                    end else begin
                        state_d = S_JX;
                        beam_d  = 1'b0;
                        vld_d   = 1'b1;
                        val_d   = cmd_x;
                        axis_d  = 1'b0;
                    end
                end
            end
            S_JX: begin
                if (xfer) begin
                    val_d   = ty_q;
                    axis_d  = 1'b1;
                    state_d = S_JY;
                end
            end
            S_JY: begin
                if (xfer) begin
                    vld_d   = 1'b0;
                    cur_x_d = tx_q;
                    cur_y_d = ty_q;
                    if (SETTLE_CYCLES == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_SETTLE;
                        cnt_d   = SETTLE_W'(SETTLE_CYCLES);
                    end
                end
            end
            S_SETTLE: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= SETTLE_W'(1)) state_d = S_IDLE;
            end
            S_DINIT: begin
                dx_d  = init_dx;
                dy_d  = init_dy;
                sx_d  = tx_q < cur_x_q;
                sy_d  = ty_q < cur_y_q;
                err_d = $signed({2'b00, init_dx}) - $signed({2'b00, init_dy});
                if (init_dx == '0 && init_dy == '0) begin
                    state_d = S_IDLE;
                end else begin
                    beam_d  = 1'b1;
                    state_d = S_DSTEP;
                end
            end
            S_DSTEP: begin
                err_d   = err_step;
                cur_x_d = nx;
                cur_y_d = ny;
                ychg_d  = stepy;
                vld_d   = 1'b1;
                if (stepx) begin
                    val_d   = nx;
                    axis_d  = 1'b0;
                    state_d = S_DX;
                end else begin
                    val_d   = ny;
                    axis_d  = 1'b1;
                    state_d = S_DY;
                end
            end
            S_DX: begin
                if (xfer) begin
                    if (ychg_q) begin
                        val_d   = cur_y_q;
                        axis_d  = 1'b1;
                        state_d = S_DY;
                    end else begin
                        vld_d   = 1'b0;
                        state_d = fin_state;
                        cnt_d   = fin_cnt;
                    end
                end
            end
            S_DY: begin
                if (xfer) begin
                    vld_d   = 1'b0;
                    state_d = fin_state;
                    cnt_d   = fin_cnt;
                end
            end
`ifdef VECTOR_SEQ_DWELL_EN
            S_DWELL: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= SETTLE_W'(1)) state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State register with synchronous active-low reset; reset drops any in-flight sample
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cur_x_q <= '0;
            cur_y_q <= '0;
            tx_q    <= '0;
            ty_q    <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            sx_q    <= 1'b0;
            sy_q    <= 1'b0;
            err_q   <= '0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            val_q   <= '0;
            axis_q  <= 1'b0;
            beam_q  <= 1'b0;
            ychg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
            tx_q    <= tx_d;
            ty_q    <= ty_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            val_q   <= val_d;
            axis_q  <= axis_d;
            beam_q  <= beam_d;
            ychg_q  <= ychg_d;
        end
    end

endmodule

// File: tb/tb_vector_sequencer.sv
// Directed self-checking bench for vector_sequencer (SETTLE_CYCLES = 4).
// Covers reset, JUMP settle timing, axial/diagonal/backwards draws and stalls.
module tb_vector_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic [11:0] cmd_x;
    logic [11:0] cmd_y;
    logic        dac_valid;
    logic        dac_ready;
    logic [11:0] dac_value;
    logic        dac_axis;
    logic        beam_on;
    logic        busy;

    always #5 clk = ~clk;

    vector_sequencer #(
        .WIDTH(12),
        .SETTLE_CYCLES(4),
        .SETTLE_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_x(cmd_x),
        .cmd_y(cmd_y),
        .dac_valid(dac_valid),
        .dac_ready(dac_ready),
        .dac_value(dac_value),
        .dac_axis(dac_axis),
        .beam_on(beam_on),
        .busy(busy)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    int          ntx, cycles, gap, stall_err, beam_bad;
    logic [11:0] tv[64];
    logic        ta[64];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command and log every DAC transfer until the DUT is idle again
    task automatic run_cmd(input logic op, input int x, input int y,
                           input bit tog);
        int          last;
        logic [11:0] hv;
        logic        ha;
        bit          held;
        ntx = 0; stall_err = 0; beam_bad = 0; last = 0;
        chk("ready_before_cmd", 32'(cmd_ready), 1);
        cmd_op = op;
        cmd_x = 12'(x);
        cmd_y = 12'(y);
        cmd_valid = 1'b1;
        dac_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        cycles = 1;
        while (busy && cycles < 500) begin
            dac_ready = tog ? cycles[0] : 1'b1;
            held = dac_valid && !dac_ready;
            hv = dac_value;
            ha = dac_axis;
            if (dac_valid && dac_ready) begin
                if (ntx < 64) begin
                    tv[ntx] = dac_value;
                    ta[ntx] = dac_axis;
                end
                ntx++;
                if (beam_on !== op) beam_bad++;
                last = cycles;
            end
            tick();
            cycles++;
            if (held && (!dac_valid || dac_value !== hv || dac_axis !== ha))
                stall_err++;
        end
        gap = cycles - last;
        dac_ready = 1'b1;
        chk("cmd_terminates", 32'(busy), 0);
    endtask

    initial begin
        logic [11:0] ev[7];
        logic        ea[7];
        int          k;

        reset = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = 1'b0;
        cmd_x = '0;
        cmd_y = '0;
        dac_ready = 1'b0;
        tick();
        tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_dac_valid", 32'(dac_valid), 0);
        chk("rst_dac_value", 32'(dac_value), 0);
        chk("rst_dac_axis", 32'(dac_axis), 0);
        chk("rst_beam_on", 32'(beam_on), 0);
        chk("rst_busy", 32'(busy), 0);
        reset = 1'b1;
        tick();

        // JUMP (100,200): X then Y, blanked, idle 5 cycles after Y transfer
        run_cmd(1'b0, 100, 200, 1'b0);
        chk("jump_ntx", 32'(ntx), 2);
        chk("jump_x_val", 32'(tv[0]), 100);
        chk("jump_x_axis", 32'(ta[0]), 0);
        chk("jump_y_val", 32'(tv[1]), 200);
        chk("jump_y_axis", 32'(ta[1]), 1);
        chk("jump_beam", 32'(beam_bad), 0);
        chk("jump_settle_gap", 32'(gap), 5);
        chk("jump_beam_after", 32'(beam_on), 0);

        // Reset while a DRAW sample is stalled
        cmd_op = 1'b1;
        cmd_x = 12'd5;
        cmd_y = 12'd5;
        cmd_valid = 1'b1;
        dac_ready = 1'b0;
        tick();
        cmd_valid = 1'b0;
        k = 0;
        while (!dac_valid && k < 20) begin
            tick();
            k++;
        end
        chk("midrst_valid_pre", 32'(dac_valid), 1);
        chk("midrst_beam_pre", 32'(beam_on), 1);
        reset = 1'b0;
        tick();
        chk("midrst_valid", 32'(dac_valid), 0);
        chk("midrst_ready", 32'(cmd_ready), 1);
        chk("midrst_beam", 32'(beam_on), 0);
        reset = 1'b1;
        dac_ready = 1'b1;

        // DRAW (2,0) after reset must start from the origin
        run_cmd(1'b1, 2, 0, 1'b0);
        chk("post_rst_ntx", 32'(ntx), 2);
        chk("post_rst_v0", 32'(tv[0]), 1);
        chk("post_rst_a0", 32'(ta[0]), 0);
        chk("post_rst_v1", 32'(tv[1]), 2);
        chk("post_rst_a1", 32'(ta[1]), 0);

        // JUMP home sends both axes
        run_cmd(1'b0, 0, 0, 1'b0);
        chk("home_ntx", 32'(ntx), 2);
        chk("home_y_val", 32'(tv[1]), 0);
        chk("home_y_axis", 32'(ta[1]), 1);

        // Axial DRAW (3,0)
        run_cmd(1'b1, 3, 0, 1'b0);
        chk("axial_ntx", 32'(ntx), 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("axial_v%0d", i), 32'(tv[i]), 32'(i + 1));
            chk($sformatf("axial_a%0d", i), 32'(ta[i]), 0);
        end
        chk("axial_beam", 32'(beam_bad), 0);
`ifdef VECTOR_SEQ_DWELL_EN
        chk("axial_end_gap", 32'(gap), 9);
`else
        chk("axial_end_gap", 32'(gap), 1);
`endif
        chk("axial_beam_after", 32'(beam_on), 1);

        // Diagonal DRAW (2,2) with dac_ready toggling
        run_cmd(1'b0, 0, 0, 1'b0);
        run_cmd(1'b1, 2, 2, 1'b1);
        chk("diag_ntx", 32'(ntx), 4);
        chk("diag_v0", 32'(tv[0]), 1);
        chk("diag_a0", 32'(ta[0]), 0);
        chk("diag_v1", 32'(tv[1]), 1);
        chk("diag_a1", 32'(ta[1]), 1);
        chk("diag_v2", 32'(tv[2]), 2);
        chk("diag_a2", 32'(ta[2]), 0);
        chk("diag_v3", 32'(tv[3]), 2);
        chk("diag_a3", 32'(ta[3]), 1);
        chk("diag_stall_stable", 32'(stall_err), 0);

        // Backwards DRAW at the top corner, no wrap
        run_cmd(1'b0, 4095, 4095, 1'b0);
        run_cmd(1'b1, 4090, 4093, 1'b0);
        ev = '{12'd4094, 12'd4093, 12'd4094, 12'd4092,
               12'd4091, 12'd4093, 12'd4090};
        ea = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        chk("corner_ntx", 32'(ntx), 7);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("corner_v%0d", i), 32'(tv[i]), 32'(ev[i]));
            chk($sformatf("corner_a%0d", i), 32'(ta[i]), 32'(ea[i]));
        end

        // Zero-length DRAW: no transfers, idle one cycle after accept
        run_cmd(1'b1, 4090, 4093, 1'b0);
        chk("zero_ntx", 32'(ntx), 0);
        chk("zero_cycles", 32'(cycles), 2);
        chk("zero_beam", 32'(beam_on), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/vector_sequencer.md
Name: vector_sequencer

Overview:
- Parametrised successor to the vector control block; single-clock command sequencer for the XY vector display path.
- Accepts JUMP/DRAW commands over a valid/ready handshake and steps lines with an internal Bresenham stepper.
- Streams per-axis samples to the DAC driver over a valid/ready handshake and drives the beam-blank output.
- Sits between the display-list fetcher and the SPI DAC driver.

Parameters:
- WIDTH, 12: coordinate and DAC sample width in bits.
- SETTLE_CYCLES, 64: blanked settle time in clk cycles after a jump's last DAC transfer; 0 allowed.
- SETTLE_W, 8: counter width; must satisfy 2^SETTLE_W > SETTLE_CYCLES.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  1  0 = JUMP, 1 = DRAW.
- cmd_x  in  WIDTH  target X, unsigned.
- cmd_y  in  WIDTH  target Y, unsigned.
- dac_valid  out  1  sample present for DAC driver.
- dac_ready  in  1  DAC driver accepts sample.
- dac_value  out  WIDTH  sample value.
- dac_axis  out  1  0 = X channel, 1 = Y channel.
- beam_on  out  1  1 = beam unblanked.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (reset == 0 at a clk edge):
  - state = IDLE; cur_x = cur_y = 0; cmd_ready = 1; dac_valid = 0; dac_value = 0; dac_axis = 0; beam_on = 0; busy = 0.
  - Reset applies in any state. An in-flight DAC sample is abandoned; dac_valid drops on the same edge.
- Command handshake:
  - cmd_ready = 1 only in IDLE.
  - A command is accepted on a cycle where cmd_valid && cmd_ready; cmd fields are latched on that edge.
- DAC handshake:
  - A transfer completes on a cycle where dac_valid && dac_ready.
  - dac_value and dac_axis stay stable while dac_valid = 1 and not yet accepted.
  - dac_valid never drops without a transfer, except on reset.
  - Within one point, X is always sent before Y.
- States: IDLE, J_X, J_Y, SETTLE, D_INIT, D_STEP, D_X, D_Y.
- JUMP path:
  - IDLE → J_X on accept. beam_on goes 0 on the accept edge; dac_valid = 1 with the X target on the next cycle.
  - J_X → J_Y on transfer, then Y target.
  - J_Y → SETTLE on transfer: cur ← target, counter loads SETTLE_CYCLES.
  - SETTLE decrements to 0, then → IDLE. With SETTLE_CYCLES = 0, J_Y goes straight to IDLE.
  - A jump always sends both axes, even if the target equals the current position.
- DRAW path:
  - IDLE → D_INIT on accept. Compute dx = |tx−cx|, dy = |ty−cy|, sx/sy = direction, err = dx−dy (signed, WIDTH+2 bits).
  - If dx = dy = 0: → IDLE next cycle, no DAC transfer, beam_on unchanged.
  - Otherwise beam_on = 1 and → D_STEP.
  - D_STEP, one cycle, with e2 = 2·err:
    - if e2 > −dy: err −= dy, x += sx.
    - if e2 < dx: err += dx, y += sy.
    - Then → D_X if x changed, else D_Y.
  - D_X sends new x; on transfer → D_Y if y changed, else back to the step decision.
  - D_Y sends new y on the same rule.
  - After the point equal to the target is sent → IDLE; beam_on stays 1 until the next JUMP.
  - The start point is never re-sent; only changed axes are sent (axial steps produce one transfer, diagonal steps two).
  - Step count equals max(dx, dy).
- Arithmetic: coordinates are unsigned WIDTH bits and never wrap; the stepper terminates exactly at the target (0 and 2^WIDTH−1 are valid endpoints).
- cmd_valid while busy: held off by cmd_ready = 0; no loss, no queueing.

Optional Feature:
- Macro: VECTOR_SEQ_DWELL_EN.
- Enabled:
  - Adds parameter DWELL_CYCLES (default 8) and state D_DWELL.
  - After the final DRAW point transfers, hold beam_on = 1 for DWELL_CYCLES cycles with busy = 1, then → IDLE. This brightens line endpoints.
  - Zero-length draws do not dwell.
- Disabled: no D_DWELL; DRAW → IDLE immediately after the final transfer, as described above.

Test Plan:
- Reset mid-DRAW (dac_valid = 1, dac_ready = 0) → next edge: dac_valid = 0, cmd_ready = 1, beam_on = 0; a following DRAW to (2,0) starts from (0,0).
- JUMP (100,200) with SETTLE_CYCLES = 4, dac_ready tied 1 → transfers X = 100 (axis 0) then Y = 200 (axis 1), beam_on = 0 throughout, cmd_ready returns 1 exactly 5 cycles after the Y transfer.
- From (0,0), DRAW (3,0) → exactly 3 transfers: axis 0 values 1, 2, 3; no Y transfers; beam_on = 1.
- From (0,0), DRAW (2,2) with dac_ready toggling 1/0 → sequence X1, Y1, X2, Y2; each value stable while stalled; ends in IDLE at (2,2).
- From (4095,4095), DRAW (4090,4093) → 5 steps ending exactly at (4090,4093), no wrap. Then DRAW (4090,4093) → zero transfers, IDLE one cycle after accept.
- With VECTOR_SEQ_DWELL_EN, DWELL_CYCLES = 8: DRAW (1,0) → busy stays 1 for 8 cycles after the final transfer with beam_on = 1.
